// File: rtl/parking_slot_if.sv
// Request/response bundle between the gate controller and the parking slot manager.
// The gate controller is the master; the slot manager is the slave.
interface parking_slot_if #(
  parameter int SLOTS = 8,
  parameter int CNT_W = 4
);
  logic             park_req;
  logic             park_auto;
  logic [SLOTS-1:0] park_loc;
  logic             leave_req;
  logic [SLOTS-1:0] leave_loc;

  logic [SLOTS-1:0] occupancy;
  logic [CNT_W-1:0] free_count;
  logic             full;
  logic             empty;
  logic             park_ack;
  logic [SLOTS-1:0] park_slot;
  logic             park_err;
  logic [1:0]       park_err_code;
  logic             leave_ack;
  logic             leave_err;
  logic [1:0]       leave_err_code;

  modport master (
    output park_req, park_auto, park_loc, leave_req, leave_loc,
    input  occupancy, free_count, full, empty,
           park_ack, park_slot, park_err, park_err_code,
           leave_ack, leave_err, leave_err_code
  );

  modport slave (
    input  park_req, park_auto, park_loc, leave_req, leave_loc,
    output occupancy, free_count, full, empty,
           park_ack, park_slot, park_err, park_err_code,
           leave_ack, leave_err, leave_err_code
  );
endinterface

// File: rtl/parking_slot_manager.sv
// Registered slot occupancy tracker: accepts one park and one leave per cycle,
// allocates manually or to the lowest free slot, and pulses ack/err responses.
module parking_slot_manager #(
  parameter int SLOTS = 8,
  parameter int CNT_W = 4
) (
  input logic           clk,
  input logic           rst_n,
  parking_slot_if.slave ps
);

  typedef enum logic [1:0] {
    PERR_NONE     = 2'b00,
    PERR_BAD_LOC  = 2'b01,
    PERR_OCCUPIED = 2'b10,
    PERR_FULL     = 2'b11
  } park_err_e;

  typedef enum logic [1:0] {
    LERR_NONE         = 2'b00,
    LERR_BAD_LOC      = 2'b01,
    LERR_ALREADY_FREE = 2'b10
  } leave_err_e;

  logic [SLOTS-1:0] occ_q;
  logic [CNT_W-1:0] free_q;
  logic             park_ack_q;
  logic [SLOTS-1:0] park_slot_q;
  park_err_e        park_code_q;
  logic             leave_ack_q;
  leave_err_e       leave_code_q;

  logic [SLOTS-1:0] free_map;
  logic [SLOTS-1:0] auto_bit;
  logic [SLOTS-1:0] park_bit;
  logic [SLOTS-1:0] leave_bit;
  park_err_e        park_code;
  leave_err_e       leave_code;
  logic             park_ok;
  logic             leave_ok;

  function automatic logic is_onehot(input logic [SLOTS-1:0] v);
    return (v != '0) && ((v & (v - SLOTS'(1))) == '0);
  endfunction

  // x & -x isolates the lowest set bit, i.e. the lowest-index free slot.
  assign free_map = ~occ_q;
  assign auto_bit = free_map & (~free_map + SLOTS'(1));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    park_bit   = '0;
    park_code  = PERR_NONE;
    leave_bit  = '0;
    leave_code = LERR_NONE;

    if (ps.park_req) begin
      if (ps.park_auto) begin
        if (free_q == '0) park_code = PERR_FULL;
        else              park_bit  = auto_bit;
      end else if (!is_onehot(ps.park_loc)) begin
        park_code = PERR_BAD_LOC;
      end else if ((occ_q & ps.park_loc) != '0) begin
        park_code = PERR_OCCUPIED;
      end else begin
        park_bit = ps.park_loc;
      end
    end

    if (ps.leave_req) begin
      if (!is_onehot(ps.leave_loc))                leave_code = LERR_BAD_LOC;
      else if ((occ_q & ps.leave_loc) == '0)       leave_code = LERR_ALREADY_FREE;
      else                                         leave_bit  = ps.leave_loc;
    end
  end

  assign park_ok  = |park_bit;
  assign leave_ok = |leave_bit;

  // Both decisions use pre-edge state, so a park into a slot being vacated
  // this cycle is still seen as occupied.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q        <= '0;
      free_q       <= CNT_W'(SLOTS);
      park_ack_q   <= 1'b0;
      park_slot_q  <= '0;
      park_code_q  <= PERR_NONE;
      leave_ack_q  <= 1'b0;
      leave_code_q <= LERR_NONE;
    end else begin
      occ_q        <= (occ_q & ~leave_bit) | park_bit;
      free_q       <= free_q - CNT_W'(park_ok) + CNT_W'(leave_ok);
      park_ack_q   <= park_ok;
      park_slot_q  <= park_bit;
      park_code_q  <= park_code;
      leave_ack_q  <= leave_ok;
      leave_code_q <= leave_code;
    end
  end

  assign ps.occupancy      = occ_q;
  assign ps.free_count     = free_q;
  assign ps.full           = (free_q == '0);
  assign ps.empty          = (free_q == CNT_W'(SLOTS));
  assign ps.park_ack       = park_ack_q;
  assign ps.park_slot      = park_slot_q;
  assign ps.park_err       = (park_code_q != PERR_NONE);
  assign ps.park_err_code  = park_code_q;
  assign ps.leave_ack      = leave_ack_q;
  assign ps.leave_err      = (leave_code_q != LERR_NONE);
  assign ps.leave_err_code = leave_code_q;

endmodule

// File: tb/tb_parking_slot_manager.sv
// Directed and random stimulus for parking_slot_manager; a behavioural slot
// model pushes expected responses to a queue, popped after each clock edge.
module tb_parking_slot_manager;

  localparam int SLOTS = 8;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [7:0] occ;
    logic [3:0] free;
    logic       full;
    logic       empty;
    logic       pack;
    logic [7:0] pslot;
    logic       perr;
    logic [1:0] pcode;
    logic       lack;
    logic       lerr;
    logic [1:0] lcode;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] m_occ = '0;
  exp_t       exp_q[$];

  parking_slot_if #(.SLOTS(SLOTS), .CNT_W(CNT_W)) ps ();

  parking_slot_manager #(.SLOTS(SLOTS), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ps    (ps)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Model: decide park/leave from the model occupancy, then update it.
  function automatic exp_t model(input logic rst, input logic pr, input logic pa,
                                 input logic [7:0] pl, input logic lr, input logic [7:0] ll);
    exp_t       e;
    logic [7:0] pbit;
    logic [7:0] lbit;
    e    = '0;
    pbit = '0;
    lbit = '0;
    if (rst) begin
      m_occ = '0;
    end else begin
      if (lr) begin
        if ($countones(ll) != 1)    begin e.lerr = 1'b1; e.lcode = 2'b01; end
        else if ((m_occ & ll) == 0) begin e.lerr = 1'b1; e.lcode = 2'b10; end
        else                        begin e.lack = 1'b1; lbit = ll; end
      end
      if (pr) begin
        if (pa) begin
          if (m_occ == 8'hFF) begin e.perr = 1'b1; e.pcode = 2'b11; end
          else begin
            for (int i = SLOTS - 1; i >= 0; i--)
              if (!m_occ[i]) pbit = 8'(1 << i);
          end
        end else if ($countones(pl) != 1) begin e.perr = 1'b1; e.pcode = 2'b01; end
        else if ((m_occ & pl) != 0)       begin e.perr = 1'b1; e.pcode = 2'b10; end
        else pbit = pl;
        if (pbit != 0) begin e.pack = 1'b1; e.pslot = pbit; end
      end
      m_occ = (m_occ & ~lbit) | pbit;
    end
    e.occ   = m_occ;
    e.free  = 4'(SLOTS - $countones(m_occ));
    e.full  = (e.free == 0);
    e.empty = (e.free == SLOTS);
    return e;
  endfunction

  task automatic step(input string name, input logic rst, input logic pr, input logic pa,
                      input logic [7:0] pl, input logic lr, input logic [7:0] ll);
    exp_t e;
    rst_n        = ~rst;
    ps.park_req  = pr;
    ps.park_auto = pa;
    ps.park_loc  = pl;
    ps.leave_req = lr;
    ps.leave_loc = ll;
    exp_q.push_back(model(rst, pr, pa, pl, lr, ll));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({name, ".occupancy"},      64'(ps.occupancy),      64'(e.occ));
    check({name, ".free_count"},     64'(ps.free_count),     64'(e.free));
    check({name, ".full"},           64'(ps.full),           64'(e.full));
    check({name, ".empty"},          64'(ps.empty),          64'(e.empty));
    check({name, ".park_ack"},       64'(ps.park_ack),       64'(e.pack));
    check({name, ".park_slot"},      64'(ps.park_slot),      64'(e.pslot));
    check({name, ".park_err"},       64'(ps.park_err),       64'(e.perr));
    check({name, ".park_err_code"},  64'(ps.park_err_code),  64'(e.pcode));
    check({name, ".leave_ack"},      64'(ps.leave_ack),      64'(e.lack));
    check({name, ".leave_err"},      64'(ps.leave_err),      64'(e.lerr));
    check({name, ".leave_err_code"}, 64'(ps.leave_err_code), 64'(e.lcode));
  endtask

  initial begin
    logic [7:0] pl;
    logic [7:0] ll;

    // Reset, then a manual park into slot 1.
    step("reset",        1, 0, 0, 8'h00, 0, 8'h00);
    step("reset_hold",   1, 1, 0, 8'h01, 0, 8'h00);
    check("reset_empty_const", 64'(ps.empty), 64'(1));
    step("park_man_02",  0, 1, 0, 8'h02, 0, 8'h00);
    check("tp1_occupancy", 64'(ps.occupancy), 64'h02);
    step("idle_loc_ign", 0, 0, 0, 8'h04, 0, 8'h02);

    // Build 0x07, then fill with auto parks; one more auto park hits full.
    step("park_man_01",  0, 1, 0, 8'h01, 0, 8'h00);
    step("park_man_04",  0, 1, 0, 8'h04, 0, 8'h00);
    step("auto_08",      0, 1, 1, 8'h00, 0, 8'h00);
    check("tp2_slot", 64'(ps.park_slot), 64'h08);
    for (int i = 0; i < 4; i++) step($sformatf("auto_fill%0d", i), 0, 1, 1, 8'h55, 0, 8'h00);
    check("tp2_full", 64'(ps.full), 64'(1));
    step("auto_full",    0, 1, 1, 8'h00, 0, 8'h00);

    // Manual error cases at full occupancy.
    step("man_two_bits", 0, 1, 0, 8'h06, 0, 8'h00);
    step("man_zero",     0, 1, 0, 8'h00, 0, 8'h00);
    step("man_occupied", 0, 1, 0, 8'h02, 0, 8'h00);

    // Park into the slot vacated on the same cycle is rejected; freed slot usable next.
    step("vacate_race",  0, 1, 0, 8'h10, 1, 8'h10);
    check("tp4_occ", 64'(ps.occupancy), 64'hEF);
    step("auto_refill",  0, 1, 1, 8'h00, 0, 8'h00);
    step("auto_full_lv", 0, 1, 1, 8'h00, 1, 8'h80);
    step("leave_free",   0, 0, 0, 8'h00, 1, 8'h80);
    step("leave_2bits",  0, 0, 0, 8'h00, 1, 8'h03);
    step("leave_zero",   0, 0, 0, 8'h00, 1, 8'h00);

    // Drain to 0x0F, then a simultaneous leave and park.
    step("leave_40",     0, 0, 0, 8'h00, 1, 8'h40);
    step("leave_20",     0, 0, 0, 8'h00, 1, 8'h20);
    step("leave_10",     0, 0, 0, 8'h00, 1, 8'h10);
    step("swap",         0, 1, 0, 8'h80, 1, 8'h01);
    check("tp5_occ", 64'(ps.occupancy), 64'h8E);

    // Reset coincident with a valid park drops the request.
    step("rst_with_park", 1, 1, 0, 8'h40, 1, 8'h02);
    step("park_after_rst", 0, 1, 0, 8'h01, 0, 8'h00);

    // Random traffic; the model derives free_count from popcount each cycle.
    for (int i = 0; i < 1000; i++) begin
      pl = ($urandom_range(0, 3) != 0) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      ll = ($urandom_range(0, 3) != 0) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      step("rand", 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pl,
           1'($urandom_range(0, 1)), ll);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/parking_slot_manager.md
Name: parking_slot_manager

Overview:
- Registered, parametrised successor to the combinational capacity calculator.
- Holds a per-slot occupancy bitmap and processes park and leave requests each clock.
- Parks either into a requested one-hot slot or into the lowest free slot (auto mode).
- Keeps a free-slot counter and full/empty flags, and reports per-request ack/error pulses to the gate controller and display logic.

Parameters:
- SLOTS, 8, number of parking slots; occupancy bitmap width; legal range 2..64.
- CNT_W, 4, free-counter width; must satisfy 2^CNT_W > SLOTS.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- park_req  in  1  park request, sampled every rising edge.
- park_auto  in  1  1 = allocate lowest free slot and ignore park_loc; 0 = use park_loc.
- park_loc  in  SLOTS  requested slot, one-hot.
- leave_req  in  1  leave request, sampled every rising edge.
- leave_loc  in  SLOTS  slot being vacated, one-hot.
- occupancy  out  SLOTS  registered bitmap; bit i = 1 means slot i is occupied.
- free_count  out  CNT_W  registered number of free slots.
- full  out  1  free_count == 0.
- empty  out  1  free_count == SLOTS.
- park_ack  out  1  one-cycle pulse: park accepted.
- park_slot  out  SLOTS  one-hot slot granted; valid while park_ack = 1, else 0.
- park_err  out  1  one-cycle pulse: park rejected.
- park_err_code  out  2  01 bad_loc, 10 occupied, 11 full; 00 when park_err = 0.
- leave_ack  out  1  one-cycle pulse: leave accepted.
- leave_err  out  1  one-cycle pulse: leave rejected.
- leave_err_code  out  2  01 bad_loc, 10 already_free; 00 when leave_err = 0.

Behaviour:
- Reset (rst_n = 0 at a rising edge):
  - occupancy = 0, free_count = SLOTS, full = 0, empty = 1.
  - All ack/err outputs, codes and park_slot = 0.
  - Reset overrides any request on the same edge; requests are dropped, not queued.
- Latency: a request sampled at edge n updates occupancy, free_count and the response pulses after edge n. One cycle, no stall, no backpressure.
- Back-to-back requests are allowed every cycle. Every response is a 1-cycle pulse; with no request, the responses return to 0.
- full and empty decode combinationally from the free_count register; no extra latency.
- Park decision, evaluated against pre-edge occupancy, first match wins:
  1. Auto mode and full → err 11.
  2. Manual mode and park_loc not exactly one-hot (zero bits or more than one bit) → err 01.
  3. Manual mode and the requested slot is occupied → err 10.
  4. Otherwise grant. In auto mode the grant is the lowest-index zero bit (priority encoder, bit 0 highest priority).
- Manual park while full → err 10, since every slot is occupied.
- Leave decision, evaluated against pre-edge occupancy:
  1. leave_loc not one-hot → err 01.
  2. Slot already free → err 10.
  3. Otherwise accept.
- Simultaneous park and leave in one cycle: both are evaluated independently against pre-edge state.
  - A park targeting the slot being vacated that same cycle → err 10 (occupied). The leave still succeeds.
  - Auto park while full plus a valid leave → err 11. The freed slot is usable from the next cycle.
  - Update: occupancy_next = (occupancy & ~leave_bit) | park_bit.
  - free_count_next = free_count − park_ok + leave_ok. Both accepted → count unchanged.
- Invariant: free_count == SLOTS − popcount(occupancy) at every cycle. The counter never wraps; the error rules make underflow and overflow unreachable.
- A rejected request leaves occupancy and free_count unchanged.
- Requests with park_req/leave_req = 0 are ignored regardless of the loc inputs.

Test Plan:
1. Reset, then manual park_loc = 8'b0000_0010 → next cycle occupancy = 8'h02, free_count = 7, park_ack = 1, park_slot = 8'h02, empty = 0.
2. From occupancy = 8'h07, auto park → park_slot = 8'h08, occupancy = 8'h0F, free_count = 4. Repeat 4 more auto parks → occupancy = 8'hFF, full = 1. Next auto park → park_err = 1, code 11, state unchanged.
3. Manual park_loc = 8'h06 (two bits) → err 01. park_loc = 8'h00 → err 01. Park into occupied slot 8'h02 → err 10. Leave of free slot 8'h80 → leave_err, code 10.
4. occupancy = 8'hFF: same cycle leave_loc = 8'h10 plus manual park_loc = 8'h10 → leave_ack = 1, park_err code 10, occupancy = 8'hEF, free_count = 1. Next cycle auto park → park_slot = 8'h10, full = 1.
5. occupancy = 8'h0F: simultaneous leave 8'h01 and manual park 8'h80 → both acked, occupancy = 8'h8E, free_count unchanged at 4.
6. Mid-sequence, rst_n = 0 coincident with a valid park → occupancy = 0, free_count = 8, no ack. Release reset and park 8'h01 → normal ack. The invariant checker (popcount) holds across a random 1000-cycle run.
